// File: rtl/mul_sequencer.sv
// Shift-add multiplier controller: latches operands, iterates WIDTH times, returns a 2*WIDTH product.
// Latency: start seen in IDLE at cycle 0 -> done pulse in cycle WIDTH+1; issue interval WIDTH+2.
// Backpressure: stall holds the PC/pipeline from the start cycle through the last RUN cycle.
module mul_sequencer #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             mul_reg_write,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;    // multiplicand magnitude, shifts left each iteration
  logic [WIDTH-1:0]   mplier;   // multiplier magnitude, shifts right each iteration
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;      // result must be negated on the way out

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] prod_fin;
  logic               last_iter;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    abs_a = (signed_mode && opa[WIDTH-1]) ? ('0 - opa) : opa;
    abs_b = (signed_mode && opb[WIDTH-1]) ? ('0 - opb) : opb;
  end

  // Accumulator step for this iteration and the final signed result (negating zero stays zero).
  always_comb begin
    acc_sum   = acc + (mplier[0] ? mcand : '0);
    prod_fin  = neg ? ('0 - acc_sum) : acc_sum;
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  // Pipeline freeze: in IDLE follow the request directly so the MUL cycle itself is held.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = start;
      RUN:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign busy          = (state != IDLE);
  assign mul_reg_write = done;

  // Controller FSM with datapath registers and registered done/product outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            neg    <= signed_mode & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            state   <= DONE;
            done    <= 1'b1;
            prod_hi <= prod_fin[2*WIDTH-1:WIDTH];
            prod_lo <= prod_fin[WIDTH-1:0];
          end
        end
        DONE: begin
          // The retiring MUL is still decoded here, so start is not looked at.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: randomized and directed multiplies against a cycle-count reference model.
// Latency: outputs compared every cycle on the falling edge once reset has been applied.
// Backpressure: start is held like the control unit does, until the done cycle has been seen.
module tb_mul_sequencer;

  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             stall;
  logic             busy;
  logic             done;
  logic             mul_reg_write;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  // Reference model: m_cnt = cycles since the request was accepted (0 = idle).
  int               m_cnt  = 0;
  logic [2*WIDTH-1:0] m_pend = '0;
  logic [2*WIDTH-1:0] m_prod = '0;

  always #5 clk = ~clk;

  mul_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .signed_mode   (signed_mode),
    .opa           (opa),
    .opb           (opb),
    .stall         (stall),
    .busy          (busy),
    .done          (done),
    .mul_reg_write (mul_reg_write),
    .prod_hi       (prod_hi),
    .prod_lo       (prod_lo)
  );

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic s);
    longint     pa;
    longint     pb;
    logic [63:0] p;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    p = pa * pb;
    return p[2*WIDTH-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on each rising edge using the inputs the DUT samples there.
  always @(posedge clk) begin
    if (reset) begin
      m_cnt  = 0;
      m_prod = '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt  = 1;
        m_pend = ref_mul(opa, opb, signed_mode);
      end
    end else if (m_cnt <= WIDTH) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == WIDTH + 1) m_prod = m_pend;
    end else begin
      m_cnt = 0;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, (m_cnt == 0) ? start : (m_cnt <= WIDTH));
      check("busy", busy, m_cnt != 0);
      check("done", done, m_cnt == WIDTH + 1);
      check("mul_reg_write", mul_reg_write, m_cnt == WIDTH + 1);
      check("prod", {prod_hi, prod_lo}, m_prod);
      if (done === 1'b1) done_cnt++;
    end
  end

  // One multiply: start held until done, optional operand toggling and start dropping in RUN.
  task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input logic [2*WIDTH-1:0] exp, input bit toggle,
                       input bit drop);
    bit found;
    found = 1'b0;
    @(posedge clk); #1;
    opa = a; opb = b; signed_mode = s; start = 1'b1;
    for (int i = 0; i < WIDTH + 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        check({name, "_latency"}, 64'(i), 64'(WIDTH + 1));
        check({name, "_stall_in_done"}, stall, 1'b0);
        check({name, "_prod"}, {prod_hi, prod_lo}, exp);
        break;
      end
      @(posedge clk); #1;
      if (toggle) begin
        opa = WIDTH'($urandom);
        opb = WIDTH'($urandom);
        signed_mode = 1'($urandom_range(0, 1));
      end
      if (drop) start = 1'($urandom_range(0, 1));
    end
    if (!found) check({name, "_done_timeout"}, 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int base;
    int first;
    int second;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rs;

    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_prod", {prod_hi, prod_lo}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases with hand-computed products.
    do_op("u3x5",   24'h000003, 24'h000005, 1'b0, 48'h000000_00000F, 1'b0, 1'b0);
    do_op("umax",   24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE_000001, 1'b0, 1'b0);
    do_op("sm1x1",  24'hFFFFFF, 24'h000001, 1'b1, 48'hFFFFFF_FFFFFF, 1'b0, 1'b0);
    do_op("smin2",  24'h800000, 24'h800000, 1'b1, 48'h400000_000000, 1'b0, 1'b0);
    do_op("s0xm5",  24'h000000, 24'hFFFFFB, 1'b1, 48'h000000_000000, 1'b0, 1'b0);
    do_op("tog",    24'h000123, 24'hFFFFFE, 1'b1, 48'hFFFFFF_FFFDBA, 1'b1, 1'b0);
    do_op("drop",   24'h000010, 24'h000010, 1'b0, 48'h000000_000100, 1'b0, 1'b1);

    // Reset in the middle of RUN aborts without a done pulse.
    @(posedge clk); #1;
    opa = 24'h000007; opb = 24'h000009; signed_mode = 1'b0; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_stall", stall, 1'b0);
    check("abort_prod", {prod_hi, prod_lo}, 0);
    base = done_cnt;
    repeat (30) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - base), 0);

    // Start held across two back-to-back multiplies.
    @(posedge clk); #1;
    opa = 24'h000002; opb = 24'h000003; signed_mode = 1'b0; start = 1'b1;
    base = done_cnt; first = -1; second = -1;
    for (int i = 0; i < 80 && second < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first < 0) begin
          first = i;
          check("b2b_p1", {prod_hi, prod_lo}, 6);
        end else begin
          second = i;
          check("b2b_p2", {prod_hi, prod_lo}, 20);
        end
      end
      @(posedge clk); #1;
      if (first >= 0 && second < 0) begin
        opa = 24'h000004; opb = 24'h000005;
      end
    end
    start = 1'b0;
    check("b2b_first_cycle", 64'(first), 64'(WIDTH + 1));
    check("b2b_second_cycle", 64'(second), 64'(2 * WIDTH + 3));
    repeat (30) @(negedge clk);
    check("b2b_pulses", 64'(done_cnt - base), 2);

    // Randomized multiplies, some with operand churn and start dropping during RUN.
    for (int n = 0; n < 30; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (n % 7 == 3) ra = 24'h800000;
      if (n % 9 == 4) rb = '0;
      do_op("rand", ra, rb, rs, ref_mul(ra, rb, rs),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
